// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: opcode constants and controller state type.
package ula_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADDU  = 4'b0100;
    localparam logic [3:0] OP_SUBU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLTU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ula_muldiv_iter.sv
// Bit-serial multiply/divide datapath working on operand magnitudes, with a final sign fix.
// Divider path is present only when ULA_SEQ_DIV_EN is defined.
module ula_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
`ifdef ULA_SEQ_DIV_EN
    input  logic             is_div,
`endif
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    input  logic             fix,
    output logic             cnt_last_c,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic [WIDTH:0]     sum_c;
    logic [2*WIDTH-1:0] prod_neg_c;
`ifdef ULA_SEQ_DIV_EN
    logic               div_q, div_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH:0]     rsh_c, diff_c;
`endif

    // acc holds the upper product / partial remainder, sr the multiplier / quotient
    always_comb begin
        mag_a_c    = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b_c    = (is_signed && b[WIDTH-1]) ? -b : b;
        sum_c      = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : '0);
        prod_neg_c = -{acc_q, sr_q};
`ifdef ULA_SEQ_DIV_EN
        rsh_c      = {acc_q, sr_q[WIDTH-1]};
        diff_c     = rsh_c - {1'b0, opnd_q};
        div_d      = div_q;
        rneg_d     = rneg_q;
`endif
        acc_d      = acc_q;
        sr_d       = sr_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;

        if (load) begin
            cnt_d  = '0;
            acc_d  = '0;
            sr_d   = mag_a_c;
            opnd_d = mag_b_c;
            qneg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ULA_SEQ_DIV_EN
            div_d  = is_div;
            rneg_d = is_signed && a[WIDTH-1];
            // Divide by zero: preload the final answer and leave nothing for the sign fix
            if (is_div && (b == '0)) begin
                acc_d  = a;
                sr_d   = '1;
                qneg_d = 1'b0;
                rneg_d = 1'b0;
            end
`endif
        end else if (step) begin
            cnt_d = CW'(cnt_q + 1'b1);
`ifdef ULA_SEQ_DIV_EN
            if (div_q) begin
                if (!diff_c[WIDTH]) begin
                    acc_d = diff_c[WIDTH-1:0];
                    sr_d  = {sr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rsh_c[WIDTH-1:0];
                    sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                acc_d = sum_c[WIDTH:1];
                sr_d  = {sum_c[0], sr_q[WIDTH-1:1]};
            end
        end else if (fix) begin
`ifdef ULA_SEQ_DIV_EN
            if (div_q) begin
                if (qneg_q) sr_d = -sr_q;
                if (rneg_q) acc_d = -acc_q;
            end else
`endif
            if (qneg_q) {acc_d, sr_d} = prod_neg_c;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            sr_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
`ifdef ULA_SEQ_DIV_EN
            div_q  <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            sr_q   <= sr_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
`ifdef ULA_SEQ_DIV_EN
            div_q  <= div_d;
            rneg_q <= rneg_d;
`endif
        end
    end

    assign cnt_last_c = (cnt_q == CW'(WIDTH - 1));
    assign res_hi     = acc_q;
    assign res_lo     = sr_q;

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative MULT/MULTU and DIV/DIVU.
// Define ULA_SEQ_DIV_EN to build the divider; otherwise DIV/DIVU complete in one cycle with S=0.
module ula_seq
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    input  logic             start,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_c;
    logic             load_c, step_c, fix_c, signed_c;
    logic             cnt_last_c;
    logic [WIDTH-1:0] res_hi, res_lo;
`ifdef ULA_SEQ_DIV_EN
    logic             is_div_c;
`endif

    // Single-cycle result; multi-cycle opcodes never use it
    always_comb begin
        case (OP)
            OP_AND:           alu_c = A & B;
            OP_OR:            alu_c = A | B;
            OP_ADD, OP_ADDU:  alu_c = A + B;
            OP_SUB, OP_SUBU:  alu_c = A - B;
            OP_SLT:           alu_c = WIDTH'($signed(A) < $signed(B));
            OP_SLTU:          alu_c = WIDTH'(A < B);
            OP_NOR:           alu_c = ~(A | B);
            OP_XOR:           alu_c = A ^ B;
            OP_MFHI:          alu_c = hi_q;
            OP_MFLO:          alu_c = lo_q;
            default:          alu_c = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        z_d      = z_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        load_c   = 1'b0;
        step_c   = 1'b0;
        fix_c    = 1'b0;
        signed_c = 1'b0;
`ifdef ULA_SEQ_DIV_EN
        is_div_c = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (OP)
                        OP_MULT, OP_MULTU: begin
                            load_c   = 1'b1;
                            signed_c = (OP == OP_MULT);
                            state_d  = ST_MUL;
                        end
`ifdef ULA_SEQ_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            load_c   = 1'b1;
                            is_div_c = 1'b1;
                            signed_c = (OP == OP_DIV);
                            state_d  = (B == '0) ? ST_FIX : ST_DIV;
                        end
`endif
                        default: begin
                            s_d    = alu_c;
                            z_d    = (alu_c == '0);
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                step_c = 1'b1;
                if (cnt_last_c) state_d = ST_FIX;
            end
            ST_FIX: begin
                fix_c   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                s_d     = res_lo;
                z_d     = (res_lo == '0);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            z_q     <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    ula_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clock      (clock),
        .reset      (reset),
        .load       (load_c),
`ifdef ULA_SEQ_DIV_EN
        .is_div     (is_div_c),
`endif
        .is_signed  (signed_c),
        .a          (A),
        .b          (B),
        .step       (step_c),
        .fix        (fix_c),
        .cnt_last_c (cnt_last_c),
        .res_hi     (res_hi),
        .res_lo     (res_lo)
    );

    assign S    = s_q;
    assign Z    = z_q;
    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: 32-bit and 8-bit instances, vector table plus multi-cycle sequences.
module tb_ula_seq;
    import ula_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] a, b, s, hi, lo;
    logic [3:0]  op;
    logic        start, z, busy, done;
    logic [7:0]  a8, b8, s8, hi8, lo8;
    logic [3:0]  op8;
    logic        start8, z8, busy8, done8;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    ula_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .A(a), .B(b), .OP(op), .start(start),
        .S(s), .Z(z), .busy(busy), .done(done), .HI(hi), .LO(lo)
    );

    ula_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .A(a8), .B(b8), .OP(op8), .start(start8),
        .S(s8), .Z(z8), .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic single(input string name, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] es);
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({name, "_s"}, 64'(s), 64'(es));
        chk({name, "_z"}, 64'(z), 64'(es == 32'h0));
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_multi(input string name, input logic [3:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                             input int ecyc, input bit hammer);
        int k;
        bit gap;
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock);
        #1;
        chk({name, "_busy_accept"}, 64'(busy), 64'd1);
        if (hammer) begin
            op = OP_ADD; a = 32'h1; b = 32'h1;
        end else begin
            start = 1'b0;
        end
        k = 0;
        gap = 1'b0;
        while (done !== 1'b1 && k < 200) begin
            @(posedge clock);
            #1;
            k++;
            if (k == 4) start = 1'b0;
            if (done !== 1'b1 && busy !== 1'b1) gap = 1'b1;
        end
        chk({name, "_cycles"}, 64'(k), 64'(ecyc));
        chk({name, "_busy_gap"}, 64'(gap), 64'd0);
        chk({name, "_hi"}, 64'(hi), 64'(ehi));
        chk({name, "_lo"}, 64'(lo), 64'(elo));
        chk({name, "_s"}, 64'(s), 64'(elo));
        chk({name, "_z"}, 64'(z), 64'(elo == 32'h0));
        chk({name, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic run8(input string name, input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo,
                        input int ecyc);
        int k;
        @(negedge clock);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        k = 0;
        while (done8 !== 1'b1 && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk({name, "_cycles"}, 64'(k), 64'(ecyc));
        chk({name, "_hi"}, 64'(hi8), 64'(ehi));
        chk({name, "_lo"}, 64'(lo8), 64'(elo));
        chk({name, "_s"}, 64'(s8), 64'(elo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0]  = '{OP_AND,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, "and"};
        vecs[1]  = '{OP_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, "or"};
        vecs[2]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, "add_ovf"};
        vecs[3]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, "add_wrap"};
        vecs[4]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, "sub_zero"};
        vecs[5]  = '{OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, "sub_neg"};
        vecs[6]  = '{OP_ADDU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, "addu"};
        vecs[7]  = '{OP_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, "subu"};
        vecs[8]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt_m1_1"};
        vecs[9]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "sltu_m1_1"};
        vecs[10] = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, "slt_1_m1"};
        vecs[11] = '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, "sltu_1_m1"};
        vecs[12] = '{OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, "slt_min_max"};
        vecs[13] = '{OP_NOR,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, "nor_zero"};
        vecs[14] = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, "nor_ones"};
        vecs[15] = '{OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, "xor"};
        vecs[16] = '{OP_SLT,  32'h00000007, 32'h00000007, 32'h00000000, "slt_eq"};
        vecs[17] = '{OP_MFHI, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, "mfhi_reset"};

        reset = 1'b1; start = 1'b0; op = OP_AND; a = '0; b = '0;
        start8 = 1'b0; op8 = OP_AND; a8 = '0; b8 = '0;
        #12;
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_z", 64'(z), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 18; i++)
            single(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s);

        single("add_pulse", OP_ADD, 32'h10, 32'h20, 32'h30);
        @(negedge clock);
        chk("done_one_cycle", 64'(done), 64'd0);

        run_multi("mult_m3_7", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 1'b1);
        single("mfhi", OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF);
        single("mflo", OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFEB);
        chk("mf_hi_kept", 64'(hi), 64'hFFFFFFFF);
        chk("mf_lo_kept", 64'(lo), 64'hFFFFFFEB);
        run_multi("multu_max_2", OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 34, 1'b0);
        run_multi("mult_min_sq", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 34, 1'b0);
        run_multi("mult_5_m1", OP_MULT, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 34, 1'b1);

`ifdef ULA_SEQ_DIV_EN
        run_multi("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b1);
        run_multi("div_7_m2", OP_DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 34, 1'b0);
        run_multi("div_by0", OP_DIV, 32'h9, 32'h0, 32'h9, 32'hFFFFFFFF, 2, 1'b0);
        run_multi("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, 1'b0);
        run_multi("divu", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 34, 1'b0);
`else
        single("pre_div_add", OP_ADD, 32'h1, 32'h1, 32'h2);
        single("div_off", OP_DIV, 32'h9, 32'h3, 32'h0);
        chk("div_off_hi", 64'(hi), 64'hFFFFFFFF);
        chk("div_off_lo", 64'(lo), 64'hFFFFFFFB);
        single("divu_off", OP_DIVU, 32'h9, 32'h0, 32'h0);
        @(negedge clock);
        chk("div_off_busy_after", 64'(busy), 64'd0);
`endif

        run8("w8_multu_ff", OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 10);
        run8("w8_mult_m1", OP_MULT, 8'hFF, 8'hFF, 8'h00, 8'h01, 10);
`ifdef ULA_SEQ_DIV_EN
        run8("w8_div_min_m1", OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80, 10);
        run8("w8_divu", OP_DIVU, 8'd200, 8'd7, 8'd4, 8'd28, 10);
`else
        @(negedge clock);
        op8 = OP_DIV; a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        chk("w8_div_off_s", 64'(s8), 64'd0);
        chk("w8_div_off_z", 64'(z8), 64'd1);
        chk("w8_div_off_done", 64'(done8), 64'd1);
        seen = busy8;
        repeat (5) begin
            @(negedge clock);
            seen = seen | busy8;
        end
        chk("w8_div_off_busy", 64'(seen), 64'd0);
        chk("w8_div_off_lo", 64'(lo8), 64'h01);
`endif

        // Reset in the middle of a multiply
        @(negedge clock);
        op = OP_MULT; a = 32'hFFFFFFFD; b = 32'h7; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_s", 64'(s), 64'd0);
        chk("mid_rst_z", 64'(z), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        chk("mid_rst_hi8", 64'(hi8), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen = seen | done | busy;
        end
        chk("mid_rst_abandoned", 64'(seen), 64'd0);
        single("mflo_after_rst", OP_MFLO, 32'h0, 32'h0, 32'h0);
        single("mfhi_after_rst", OP_MFHI, 32'h0, 32'h0, 32'h0);
        run_multi("mult_after_rst", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
